stone_drawer: RTL

- Reader side of the object-RAM draw interface. Once per frame it scans the object RAM (one 32-bit word per stone/gold/diamond).
- For every visible object it rasterises a SPRITE_SIZE x SPRITE_SIZE box, one pixel per cycle, to the VGA adapter's plot port.
- It asserts draw_flag/draw_index to borrow the RAM read address from the rope controller. That controller stalls its FSM while draw_flag is high.

---
 rtl/stone_pkg.sv | 49 ++++
 rtl/sprite_raster.sv | 127 ++++++++++++
 rtl/stone_drawer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/stone_pkg.sv
// Shared definitions for the stone drawer: object-word layout, type codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stone_pkg;

    // Object word layout: x=[31:23], y=[18:11], type=[3:2], visible=[1], moving=[0]
    localparam int X_LSB    = 23;
    localparam int X_W      = 9;
    localparam int Y_LSB    = 11;
    localparam int Y_W      = 8;
    localparam int TYPE_LSB = 2;
    localparam int TYPE_W   = 2;
    localparam int VIS_BIT  = 1;
    localparam int MOV_BIT  = 0;

    localparam logic [1:0] TYPE_STONE   = 2'b00;
    localparam logic [1:0] TYPE_GOLD    = 2'b01;
    localparam logic [1:0] TYPE_DIAMOND = 2'b10;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_ADDR,
        S_WAIT,
        S_LATCH,
        S_PLOT,
        S_NEXT,
        S_DONE
    } state_t;

    // Types 10 and 11 both render as diamond.
    function automatic logic [2:0] type_colour(
        input logic [1:0] obj_type,
        input logic [2:0] c_stone,
        input logic [2:0] c_gold,
        input logic [2:0] c_diamond
    );
        logic [2:0] col;
        case (obj_type)
            TYPE_STONE: col = c_stone;
            TYPE_GOLD:  col = c_gold;
            default:    col = c_diamond;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/sprite_raster.sv
// Sprite rasteriser: walks a SPRITE_SIZE square row-major and drives clipped, registered plot outputs.
// Latency: pixel (0,0) is on the outputs the cycle after i_load; one pixel per i_step cycle after that.
// Backpressure: none; STONE_ROUND_EN masks the four corner pixels (cycle timing unchanged).
module sprite_raster
    import stone_pkg::*;
#(
    parameter int SPRITE_SIZE = 16,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF
)(
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [8:0] i_x,
    input  logic [7:0] i_y,
    input  logic [2:0] i_colour,
    output logic [8:0] o_vga_x,
    output logic [7:0] o_vga_y,
    output logic [2:0] o_vga_colour,
    output logic       o_vga_plot,
    output logic       o_last
);

    localparam int            CW    = $clog2(SPRITE_SIZE);
    localparam logic [CW-1:0] P_MAX = CW'(SPRITE_SIZE - 1);
    localparam logic [CW-1:0] P_ONE = CW'(1);

    // r_px/r_py always index the pixel currently shown on the outputs.
    logic [CW-1:0] r_px;
    logic [CW-1:0] r_py;
    // Latched object: base coordinates and colour.
    logic [8:0]    r_bx;
    logic [7:0]    r_by;
    logic [2:0]    r_col;
    logic [8:0]    r_vga_x;
    logic [7:0]    r_vga_y;
    logic [2:0]    r_vga_colour;
    logic          r_vga_plot;

    logic [CW-1:0] w_nx;
    logic [CW-1:0] w_ny;
    logic [8:0]    w_bx;
    logic [7:0]    w_by;
    logic [2:0]    w_col;
    logic          w_active;
    logic          w_last;
    logic [9:0]    w_sx;
    logic [9:0]    w_sy;
    logic          w_in_screen;
    logic          w_corner;
    logic          w_unused_sum;

    assign w_last = (r_px == P_MAX) && (r_py == P_MAX);

    // Next pixel to show: restart at (0,0) on load, otherwise advance row-major until the last pixel.
    always_comb begin
        w_nx     = r_px;
        w_ny     = r_py;
        w_bx     = r_bx;
        w_by     = r_by;
        w_col    = r_col;
        w_active = 1'b0;
        if (i_load) begin
            w_nx     = '0;
            w_ny     = '0;
            w_bx     = i_x;
            w_by     = i_y;
            w_col    = i_colour;
            w_active = 1'b1;
        end else if (i_step && !w_last) begin
            w_active = 1'b1;
            if (r_px == P_MAX) begin
                w_nx = '0;
                w_ny = r_py + P_ONE;
            end else begin
                w_nx = r_px + P_ONE;
            end
        end
    end

    // Sums are 10 bits so coordinates past 511/255 still clip instead of wrapping on screen.
    assign w_sx         = 10'(w_bx) + 10'(w_nx);
    assign w_sy         = 10'(w_by) + 10'(w_ny);
    assign w_in_screen  = (w_sx < 10'(SCREEN_W)) && (w_sy < 10'(SCREEN_H));
    assign w_unused_sum = ^{w_sx[9], w_sy[9:8]};

`ifdef STONE_ROUND_EN
    assign w_corner = ((w_nx == '0) || (w_nx == P_MAX)) && ((w_ny == '0) || (w_ny == P_MAX));
`else
    assign w_corner = 1'b0;
`endif

    // Register counters and the pixel; plot drops as soon as the walk is no longer active.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_px         <= '0;
            r_py         <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_col        <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_px       <= w_nx;
            r_py       <= w_ny;
            r_bx       <= w_bx;
            r_by       <= w_by;
            r_col      <= w_col;
            r_vga_plot <= w_active && w_in_screen && !w_corner;
            if (w_active) begin
                r_vga_x      <= w_sx[8:0];
                r_vga_y      <= w_sy[7:0];
                r_vga_colour <= w_col;
            end
        end
    end

    assign o_vga_x      = r_vga_x;
    assign o_vga_y      = r_vga_y;
    assign o_vga_colour = r_vga_colour;
    assign o_vga_plot   = r_vga_plot;
    assign o_last       = w_last;

endmodule

// File: rtl/stone_drawer.sv
// Object-RAM reader: scans quantity objects per start pulse and rasterises each visible one.
// Latency: 1+RAM_LATENCY+1+SPRITE_SIZE^2+1 cycles per visible object, 3+RAM_LATENCY per hidden one, then done.
// Backpressure: none; the rope controller stalls while draw_flag is high. Macro STONE_ROUND_EN rounds sprite corners.
module stone_drawer
    import stone_pkg::*;
#(
    parameter int         SPRITE_SIZE    = 16,
    parameter int         RAM_LATENCY    = 2,
    parameter int         SCREEN_W       = SCREEN_W_DEF,
    parameter int         SCREEN_H       = SCREEN_H_DEF,
    parameter logic [2:0] COLOUR_STONE   = 3'b011,
    parameter logic [2:0] COLOUR_GOLD    = 3'b110,
    parameter logic [2:0] COLOUR_DIAMOND = 3'b101
)(
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] ram_q,
    output logic        draw_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

    state_t     r_state;
    logic [3:0] r_idx;
    logic [1:0] r_wait;
    logic       r_draw_flag;
    logic [3:0] r_draw_index;
    logic       r_busy;
    logic       r_done;

    logic [8:0] w_obj_x;
    logic [7:0] w_obj_y;
    logic [1:0] w_obj_type;
    logic       w_visible;
    logic [2:0] w_obj_colour;
    logic       w_load;
    logic       w_step;
    logic       w_last;
    logic       w_more;
    logic       w_unused_fields;

    assign w_obj_x         = ram_q[X_LSB +: X_W];
    assign w_obj_y         = ram_q[Y_LSB +: Y_W];
    assign w_obj_type      = ram_q[TYPE_LSB +: TYPE_W];
    assign w_visible       = ram_q[VIS_BIT];
    // The moving bit and the gaps between fields play no part in drawing.
    assign w_unused_fields = ^{ram_q[22:19], ram_q[10:4], ram_q[MOV_BIT]};
    assign w_obj_colour    = type_colour(w_obj_type, COLOUR_STONE, COLOUR_GOLD, COLOUR_DIAMOND);

    // The raster's load register is the object latch: it captures x/y/colour in S_LATCH.
    assign w_load = (r_state == S_LATCH) && w_visible;
    assign w_step = (r_state == S_PLOT);
    // quantity is re-read here every S_NEXT, so a mid-scan drop to <= idx ends the scan.
    assign w_more = ({1'b0, r_idx} + 5'd1) < {1'b0, quantity};

    // Scan FSM; draw_flag/draw_index/busy/done are registered so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_wait       <= '0;
            r_draw_flag  <= 1'b0;
            r_draw_index <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (quantity == 4'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_SET_ADDR;
                            r_idx        <= '0;
                            r_wait       <= '0;
                            r_draw_flag  <= 1'b1;
                            r_draw_index <= '0;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                S_SET_ADDR: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= S_LATCH;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_LATCH: begin
                    // Hand the RAM address back to the rope FSM while we rasterise.
                    r_draw_flag <= 1'b0;
                    r_state     <= w_visible ? S_PLOT : S_NEXT;
                end
                S_PLOT: begin
                    if (w_last) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_more) begin
                        r_idx        <= r_idx + 4'd1;
                        r_draw_index <= r_idx + 4'd1;
                        r_draw_flag  <= 1'b1;
                        r_wait       <= '0;
                        r_state      <= S_SET_ADDR;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sprite_raster #(
        .SPRITE_SIZE (SPRITE_SIZE),
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H)
    ) u_raster (
        .clock        (clock),
        .resetn       (resetn),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_x          (w_obj_x),
        .i_y          (w_obj_y),
        .i_colour     (w_obj_colour),
        .o_vga_x      (vga_x),
        .o_vga_y      (vga_y),
        .o_vga_colour (vga_colour),
        .o_vga_plot   (vga_plot),
        .o_last       (w_last)
    );

    assign draw_flag  = r_draw_flag;
    assign draw_index = r_draw_index;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
